uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one 9N1 `uart_tx` transmitter between `NUM_REQ` requesters. It sits between the producers of 9-bit words (status, telemetry, command echo) and the single `uart_tx` instance. It latches the winning word, issues a one-cycle `send` pulse, then tracks the transmitter's `ready` through one complete frame before granting again. An optional watchdog recovers from a transmitter that never starts or never finishes a frame.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `WDOG_CYCLES`, default 8192: watchdog limit in clock cycles. Used only when the watchdog is compiled in.

- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester request, level. Must be held with data stable until acked.
- `req_data`  in  NUM_REQ*9  requester i's word at bits [9*i+8 : 9*i].
- `ack`  out  NUM_REQ  one-hot, one-cycle pulse when a requester's word is taken.
- `uart_send`  out  1  to `uart_tx.send`. One-cycle pulse.
- `uart_data`  out  9  to `uart_tx.data`. Holds the latched word.
- `uart_ready`  in  1  from `uart_tx.ready`. High when the transmitter is idle.
- `busy`  out  1  high whenever state is not IDLE.
- `timeout`  out  1  one-cycle pulse on a watchdog abort. Constant 0 when the watchdog is compiled out.

## Operation
- The FSM has four states: IDLE, SEND, WAIT_LOW, WAIT_HIGH. All outputs are registered.
- Reset values: state IDLE; `ack`=0; `uart_send`=0; `uart_data`=0; `busy`=0; `timeout`=0; round-robin pointer `last` = NUM_REQ-1, so requester 0 has first priority; watchdog count 0.
- IDLE: if `uart_ready`=1 and `req`≠0, pick the first set bit searching from `last`+1 upward, modulo NUM_REQ.
  - Latch that requester's word into `uart_data`.
  - Set `last` to the winner.
  - Go to SEND.
  - Otherwise stay in IDLE.
- SEND, exactly one cycle: `uart_send`=1 and `ack[winner]`=1. Go to WAIT_LOW.
- WAIT_LOW: stay until `uart_ready`=0, then go to WAIT_HIGH. This confirms the transmitter accepted the word.
- WAIT_HIGH: stay until `uart_ready`=1, then go to IDLE. This marks the frame as complete.
- `uart_data` stays constant from SEND until the next grant.
- Requesters are sampled only in IDLE.
  - A request dropped before a grant is withdrawn without side effects.
  - A requester that keeps `req` high after its ack is treated as having a new word. It is served again only after every other active requester has had a turn.

## Timing
- Grant decision at edge N (in IDLE) → `uart_send` and `ack` high during cycle N+1 → low at N+2.
- Minimum spacing between `send` pulses is 4 cycles plus the frame time: one cycle each in IDLE and SEND, at least one in WAIT_LOW, at least one in WAIT_HIGH.
- `uart_ready`=0 while in IDLE (transmitter busy from elsewhere or still finishing): no grant is made and `req` is held pending.
- A request that rises in the same cycle the FSM returns to IDLE takes part in arbitration on the next edge.
- Arbitration across simultaneous requests is strictly round-robin, with no starvation. The worst-case wait is NUM_REQ-1 frames.
- Reset asserted mid-frame:
  - All outputs return to their reset values immediately (asynchronous).
  - The in-flight word is not retried.
  - A requester whose ack already pulsed must not re-present that word.

## Configuration
- `UART_TX_ARBITER_WATCHDOG_EN` defined:
  - A counter clears on entry to SEND and increments every cycle in WAIT_LOW and WAIT_HIGH.
  - When the count reaches WDOG_CYCLES-1 and the state is still WAIT_LOW/WAIT_HIGH, the FSM goes to IDLE on the next edge and `timeout` pulses for one cycle.
  - `last` is kept, so the next grant goes to the next requester in order.
- `UART_TX_ARBITER_WATCHDOG_EN` undefined: no counter; `timeout` is tied to 0; WAIT_LOW and WAIT_HIGH wait indefinitely.

## Test plan
- Single request, requester 2, word 9'h1AB, with a `uart_tx` model → one `ack[2]` pulse in the same cycle as `uart_send`; `uart_data`=9'h1AB; `busy` high until `ready` returns; no second send.
- All four requesting continuously after reset → grant order 0,1,2,3,0,1; exactly one `uart_send` per frame; each `ack` one-hot.
- `uart_ready` forced 0 in IDLE with `req`=4'b0001 → no `send` and no `ack` until `ready`=1; the grant then follows one edge later.
- Reset pulsed low during WAIT_HIGH → `uart_send`, `ack` and `busy` are 0 immediately; after release, requester 0 wins first.
- Watchdog build with WDOG_CYCLES=16 and `ready` stuck high after `send` → `timeout` pulses exactly 16 cycles after SEND; the FSM returns to IDLE; the next pending requester is granted.
- Non-watchdog build, same stimulus → stays in WAIT_LOW; `timeout` is never asserted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 9N1 uart_tx between NUM_REQ requesters.
// Optional watchdog: define UART_TX_ARBITER_WATCHDOG_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WDOG_CYCLES = 8192
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*9-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 uart_send,
  output logic [8:0]           uart_data,
  input  logic                 uart_ready,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_LOW,
    WAIT_HIGH
  } state_t;

  if (NUM_REQ < 2 || NUM_REQ > 16 || WDOG_CYCLES < 3) begin : g_bad_param
    $error("uart_tx_arbiter: parameter out of range");
  end

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic          found;
  logic [8:0]    words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = req_data[9*g +: 9];
  end

  // First active requester after the last winner, wrapping around.
  always_comb begin
    win   = last;
    cand  = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  logic grant;
  assign grant = (state == IDLE) && uart_ready && found;

`ifdef UART_TX_ARBITER_WATCHDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES);
  logic [CW-1:0] wcnt;
  logic          waiting;
  logic          wdog_hit;
  assign waiting  = (state == WAIT_LOW) || (state == WAIT_HIGH);
  // Abort lands so timeout is seen WDOG_CYCLES cycles after the send pulse.
  assign wdog_hit = waiting && (wcnt == CW'(WDOG_CYCLES - 2));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ack       <= '0;
      uart_send <= 1'b0;
      uart_data <= '0;
      busy      <= 1'b0;
      last      <= IW'(NUM_REQ - 1);
`ifdef UART_TX_ARBITER_WATCHDOG_EN
      timeout   <= 1'b0;
      wcnt      <= '0;
`endif
    end else begin
      ack       <= '0;
      uart_send <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            uart_data <= words[win];
            last      <= win;
            ack       <= NUM_REQ'(1) << win;
            uart_send <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: state <= WAIT_LOW;
        WAIT_LOW: begin
          if (!uart_ready) state <= WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (uart_ready) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef UART_TX_ARBITER_WATCHDOG_EN
      timeout <= 1'b0;
      if (waiting) wcnt <= wcnt + 1'b1;
      else         wcnt <= '0;
      if (wdog_hit) begin
        state   <= IDLE;
        busy    <= 1'b0;
        timeout <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural uart_tx model
// and a round-robin reference computed from the pending request set.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int WD = 16;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*9-1:0] req_data;
  logic [N-1:0]   ack;
  logic           uart_send;
  logic [8:0]     uart_data;
  logic           uart_ready;
  logic           busy;
  logic           timeout;

  logic [8:0] words [N];
  int checks = 0;
  int errors = 0;
  int ref_last;

  logic tx_ready_m;
  logic tx_hold;
  logic tx_stuck;
  int   tx_cnt;
  int   frame_len;

  uart_tx_arbiter #(.NUM_REQ(N), .WDOG_CYCLES(WD)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .uart_send  (uart_send),
    .uart_data  (uart_data),
    .uart_ready (uart_ready),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clock = ~clock;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[9*i +: 9] = words[i];
  end

  assign uart_ready = tx_ready_m & ~tx_hold;

  // Transmitter: goes busy on send, stays busy frame_len cycles.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_ready_m <= 1'b1;
      tx_cnt     <= 0;
    end else if (uart_send && !tx_stuck) begin
      tx_ready_m <= 1'b0;
      tx_cnt     <= frame_len;
    end else if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_ready_m <= 1'b1;
    end
  end

  function automatic int rr_pick(input logic [N-1:0] m, input int lst);
    for (int i = 1; i <= N; i++) begin
      if (m[(lst + i) % N]) return (lst + i) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset_n   = 1'b0;
    req       = '0;
    tx_hold   = 1'b0;
    tx_stuck  = 1'b0;
    frame_len = $urandom_range(2, 6);
    for (int i = 0; i < N; i++) words[i] = 9'($urandom);
    repeat (2) @(negedge clock);
    reset_n  = 1'b1;
    ref_last = N - 1;
    @(negedge clock);
  endtask

  task automatic wait_send(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (uart_send) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = '1;
    @(negedge clock);
    checks++;
    if ({ack, uart_send, uart_data, busy, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b send=%b data=%h busy=%b to=%b, need all 0",
               ack, uart_send, uart_data, busy, timeout);
    end
    do_reset();
    checks++;
    if (busy !== 1'b0 || uart_send !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b send=%b, need 0 0", busy, uart_send);
    end
  endtask

  task automatic test_single();
    bit got;
    int extra;
    bit idle_seen;
    do_reset();
    words[2] = 9'h1AB;
    req      = 4'b0100;
    wait_send(20, got);
    checks++;
    if (!got || ack !== 4'b0100 || uart_data !== 9'h1AB || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got=%b ack=%b data=%h busy=%b, need 1 0100 1ab 1",
               got, ack, uart_data, busy);
    end
    req       = '0;
    extra     = 0;
    idle_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (uart_send) extra++;
      if (!idle_seen && !busy) begin
        idle_seen = 1'b1;
        checks++;
        if (uart_ready !== 1'b1) begin
          errors++;
          $display("FAIL single_busy_drop: ready=%b at busy fall, need 1", uart_ready);
        end
      end
    end
    checks++;
    if (!idle_seen || extra != 0) begin
      errors++;
      $display("FAIL single_tail: idle=%b extra_sends=%0d, need 1 0", idle_seen, extra);
    end
  endtask

  task automatic test_all_four();
    bit got;
    int exp;
    do_reset();
    req = '1;
    for (int k = 0; k < 6; k++) begin
      wait_send(40, got);
      exp = k % N;
      checks++;
      if (!got || ack !== N'(1 << exp) || uart_data !== words[exp]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got=%b ack=%b data=%h, need ack=%b data=%h",
                 k, got, ack, uart_data, N'(1 << exp), words[exp]);
      end
      words[exp] = 9'($urandom);
      @(negedge clock);
      checks++;
      if (uart_send !== 1'b0 || ack !== '0) begin
        errors++;
        $display("FAIL rr_pulse_width[%0d]: send=%b ack=%b, need 0 0", k, uart_send, ack);
      end
    end
    req = '0;
  endtask

  task automatic test_random();
    int grants;
    int exp;
    int cyc;
    do_reset();
    grants = 0;
    cyc    = 0;
    while (grants < 40 && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      if (uart_send) begin
        exp = rr_pick(req, ref_last);
        checks++;
        if (exp < 0 || ack !== N'(1 << exp) || uart_data !== words[exp]) begin
          errors++;
          $display("FAIL rand_grant[%0d]: req=%b ack=%b data=%h, need winner %0d",
                   grants, req, ack, uart_data, exp);
        end
        if (exp >= 0) begin
          ref_last = exp;
          if ($urandom_range(0, 1) == 1) req[exp] = 1'b0;
          else words[exp] = 9'($urandom);
        end
        frame_len = $urandom_range(2, 6);
        grants++;
      end else if (ack !== '0) begin
        checks++;
        errors++;
        $display("FAIL rand_stray_ack: ack=%b without send", ack);
      end
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          words[i] = 9'($urandom);
          req[i]   = 1'b1;
        end
      end
    end
    checks++;
    if (grants < 40) begin
      errors++;
      $display("FAIL rand_progress: grants=%0d, need 40", grants);
    end
    req = '0;
  endtask

  task automatic test_ready_low();
    int seen;
    do_reset();
    tx_hold = 1'b1;
    req     = 4'b0001;
    seen    = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (uart_send || ack !== '0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL ready_low_hold: %0d cycles with send/ack, need 0", seen);
    end
    tx_hold = 1'b0;
    @(negedge clock);
    checks++;
    if (uart_send !== 1'b1 || ack !== 4'b0001) begin
      errors++;
      $display("FAIL ready_low_release: send=%b ack=%b, need 1 0001", uart_send, ack);
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    bit got;
    bit low;
    do_reset();
    frame_len = 6;
    req       = '1;
    wait_send(20, got);
    low = 1'b0;
    for (int i = 0; i < 20 && !low; i++) begin
      @(negedge clock);
      low = !uart_ready;
    end
    @(negedge clock);
    checks++;
    if (!got || !low || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: got=%b low=%b busy=%b, need 1 1 1", got, low, busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (uart_send !== 1'b0 || ack !== '0 || busy !== 1'b0 || uart_data !== '0) begin
      errors++;
      $display("FAIL mid_async: send=%b ack=%b busy=%b data=%h, need 0",
               uart_send, ack, busy, uart_data);
    end
    @(negedge clock);
    reset_n = 1'b1;
    wait_send(20, got);
    checks++;
    if (!got || ack !== 4'b0001) begin
      errors++;
      $display("FAIL mid_first_after: got=%b ack=%b, need 1 0001", got, ack);
    end
    req = '0;
  endtask

  task automatic test_stuck();
    bit got;
    do_reset();
    tx_stuck = 1'b1;
    req      = 4'b0010;
    wait_send(20, got);
    checks++;
    if (!got || ack !== 4'b0010) begin
      errors++;
      $display("FAIL stuck_grant: got=%b ack=%b, need 1 0010", got, ack);
    end
    req = 4'b1000;
`ifdef UART_TX_ARBITER_WATCHDOG_EN
    begin
      int hit;
      hit = 0;
      for (int i = 1; i <= 40 && hit == 0; i++) begin
        @(negedge clock);
        if (timeout) hit = i;
      end
      checks++;
      if (hit != WD || busy !== 1'b0) begin
        errors++;
        $display("FAIL wdog_timeout: at %0d busy=%b, need %0d 0", hit, busy, WD);
      end
      @(negedge clock);
      checks++;
      if (timeout !== 1'b0 || uart_send !== 1'b1 || ack !== 4'b1000) begin
        errors++;
        $display("FAIL wdog_next: to=%b send=%b ack=%b, need 0 1 1000",
                 timeout, uart_send, ack);
      end
    end
`else
    begin
      int to_seen;
      int idle_seen;
      int sends;
      to_seen   = 0;
      idle_seen = 0;
      sends     = 0;
      for (int i = 0; i < 3 * WD; i++) begin
        @(negedge clock);
        if (timeout !== 1'b0) to_seen++;
        if (busy !== 1'b1) idle_seen++;
        if (uart_send) sends++;
      end
      checks++;
      if (to_seen != 0 || idle_seen != 0 || sends != 0) begin
        errors++;
        $display("FAIL stuck_wait: timeouts=%0d idle=%0d sends=%0d, need 0 0 0",
                 to_seen, idle_seen, sends);
      end
    end
`endif
    do_reset();
  endtask

  initial begin
    reset_n   = 1'b0;
    req       = '0;
    tx_hold   = 1'b0;
    tx_stuck  = 1'b0;
    frame_len = 3;
    for (int i = 0; i < N; i++) words[i] = '0;
    test_reset();
    test_single();
    test_all_four();
    test_random();
    test_ready_low();
    test_reset_mid();
    test_stuck();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
